// File: rtl/awgn_burst_channel.sv
// Burst-noise channel: an LFSR-driven Markov state selects a per-state Q1.7 gain applied to AWGN samples.
// One-cycle latency from tick to noise_out/noise_valid; no backpressure, one sample per tick at full clock rate.
module awgn_burst_channel #(
   parameter int          NOISE_W       = 16,
   parameter int          STATE_W       = 2,
   parameter int          DWELL_W       = 16,
   parameter logic [15:0] SEED          = 16'hACE1,
   parameter int          DEFAULT_DWELL = 1000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tick,
   input  logic [NOISE_W-1:0] noise_in,
   input  logic               cfg_we,
   input  logic [STATE_W-1:0] cfg_addr,
   input  logic [7:0]         cfg_gain,
   input  logic [DWELL_W-1:0] cfg_dwell,
   output logic [NOISE_W-1:0] noise_out,
   output logic               noise_valid,
   output logic [STATE_W-1:0] cur_state,
   output logic               state_change
);
   localparam int                 NUM_STATES = 2 ** STATE_W;
   localparam int                 PW         = NOISE_W + 9;
   localparam logic [15:0]        LFSR_INIT  = (SEED == 16'h0000) ? 16'hACE1 : SEED;
   localparam logic [DWELL_W-1:0] ONE        = DWELL_W'(1);
   localparam logic [DWELL_W-1:0] DEF_DWELL  = DWELL_W'(DEFAULT_DWELL);
   localparam logic [DWELL_W-1:0] DEF_CNT    = (DEF_DWELL == '0) ? '0 : DEF_DWELL - ONE;
   localparam logic signed [PW-1:0] SAT_MAX  = {{10{1'b0}}, {(NOISE_W-1){1'b1}}};
   localparam logic signed [PW-1:0] SAT_MIN  = {{10{1'b1}}, {(NOISE_W-1){1'b0}}};

   logic [7:0]         gain  [NUM_STATES];
   logic [DWELL_W-1:0] dwell [NUM_STATES];
   logic [DWELL_W-1:0] dwell_cnt;
   logic [15:0]        lfsr;

   logic signed [PW-1:0] noise_ext;
   logic signed [PW-1:0] gain_ext;
   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] scaled;
   logic [NOISE_W-1:0]   noise_sat;
   logic [STATE_W-1:0]   next_state;
   logic [DWELL_W-1:0]   next_dwell;
   logic [DWELL_W-1:0]   entry_cnt;
   logic [15:0]          lfsr_next;

   always_comb begin
      noise_ext = {{9{noise_in[NOISE_W-1]}}, noise_in};
      gain_ext  = {{(NOISE_W+1){1'b0}}, gain[cur_state]};
      prod      = noise_ext * gain_ext;
      // Arithmetic shift gives floor division by 128 for negative products.
      scaled    = prod >>> 7;
      noise_sat = scaled[NOISE_W-1:0];
      if (scaled > SAT_MAX)
         noise_sat = SAT_MAX[NOISE_W-1:0];
      else if (scaled < SAT_MIN)
         noise_sat = SAT_MIN[NOISE_W-1:0];
   end

   always_comb begin
      next_state = lfsr[STATE_W-1:0];
      next_dwell = dwell[next_state];
      // A zero dwell behaves as a one-tick dwell.
      entry_cnt  = (next_dwell == '0) ? '0 : next_dwell - ONE;
      lfsr_next  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_STATES; i++) begin
            gain[i]  <= 8'd128;
            dwell[i] <= DEF_DWELL;
         end
         cur_state    <= '0;
         dwell_cnt    <= DEF_CNT;
         lfsr         <= LFSR_INIT;
         noise_out    <= '0;
         noise_valid  <= 1'b0;
         state_change <= 1'b0;
      end else begin
         noise_valid  <= tick;
         state_change <= 1'b0;
         if (cfg_we) begin
            gain[cfg_addr]  <= cfg_gain;
            dwell[cfg_addr] <= cfg_dwell;
         end
         if (tick) begin
            noise_out <= noise_sat;
            lfsr      <= lfsr_next;
            if (dwell_cnt != '0) begin
               dwell_cnt <= dwell_cnt - ONE;
            end else begin
               cur_state    <= next_state;
               dwell_cnt    <= entry_cnt;
               state_change <= (next_state != cur_state);
            end
         end
      end
   end
endmodule

// File: tb/tb_awgn_burst_channel.sv
// Directed and randomized bench for awgn_burst_channel against a tick-level behavioural model.
module tb_awgn_burst_channel;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               reset = 1'b1;
   logic               tick = 1'b0;
   logic signed [15:0] noise_in = '0;
   logic               cfg_we = 1'b0;
   logic [1:0]         cfg_addr = '0;
   logic [7:0]         cfg_gain = '0;
   logic [15:0]        cfg_dwell = '0;

   logic [15:0] noise_out, noise_out_b;
   logic        noise_valid, noise_valid_b;
   logic [1:0]  cur_state, cur_state_b;
   logic        state_change, state_change_b;

   awgn_burst_channel u_dut (
      .clk(clk), .reset(reset), .tick(tick), .noise_in(noise_in),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_gain(cfg_gain), .cfg_dwell(cfg_dwell),
      .noise_out(noise_out), .noise_valid(noise_valid),
      .cur_state(cur_state), .state_change(state_change)
   );

   // Zero seed must fall back to 16'hACE1, so this instance tracks the same model.
   awgn_burst_channel #(.SEED(16'h0000)) u_dut_seed0 (
      .clk(clk), .reset(reset), .tick(tick), .noise_in(noise_in),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_gain(cfg_gain), .cfg_dwell(cfg_dwell),
      .noise_out(noise_out_b), .noise_valid(noise_valid_b),
      .cur_state(cur_state_b), .state_change(state_change_b)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Model: m_left = ticks remaining in the current state including the present one.
   int                 m_gain [4];
   int                 m_dwell[4];
   int                 m_lfsr, m_state, m_left;
   logic signed [15:0] exp_out;
   bit                 exp_valid, exp_chg;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("noise_out",    {16'h0, noise_out},   {16'h0, exp_out});
      chk("noise_valid",  {31'h0, noise_valid}, {31'h0, exp_valid});
      chk("cur_state",    {30'h0, cur_state},   32'(m_state));
      chk("state_change", {31'h0, state_change}, {31'h0, exp_chg});
      chk("seed0_state",  {30'h0, cur_state_b}, 32'(m_state));
      chk("seed0_out",    {16'h0, noise_out_b}, {16'h0, exp_out});
   endtask

   function automatic logic signed [15:0] scale(input int n, input int g);
      longint p, y;
      p = longint'(n) * longint'(g);
      y = (p >= 0) ? p / 128 : -((-p + 127) / 128);
      if (y > 32767) y = 32767;
      if (y < -32768) y = -32768;
      return 16'(y);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_gain[i]  = 128;
         m_dwell[i] = 1000;
      end
      m_lfsr = 'hACE1; m_state = 0; m_left = 1000;
      exp_out = '0; exp_valid = 0; exp_chg = 0;
   endtask

   task automatic do_reset(input bit t, input bit we);
      reset = 1'b1; tick = t; cfg_we = we; cfg_addr = 2'd0; cfg_gain = 8'd7;
      cfg_dwell = 16'd1; noise_in = 16'sd123;
      @(posedge clk); @(negedge clk);
      reset = 1'b0; tick = 1'b0; cfg_we = 1'b0;
      model_reset();
      check_all();
   endtask

   task automatic step(input bit t, input logic signed [15:0] n, input bit we,
                       input int a, input int g, input int d);
      int nx;
      tick = t; noise_in = n; cfg_we = we;
      cfg_addr = 2'(a); cfg_gain = 8'(g); cfg_dwell = 16'(d);
      exp_valid = t; exp_chg = 0;
      if (t) begin
         exp_out = scale(int'(n), m_gain[m_state]);
         if (m_left == 1) begin
            nx      = m_lfsr % 4;
            exp_chg = (nx != m_state);
            m_state = nx;
            m_left  = (m_dwell[nx] == 0) ? 1 : m_dwell[nx];
         end else begin
            m_left--;
         end
         m_lfsr = (m_lfsr >> 1) ^ (((m_lfsr & 1) != 0) ? 'hB400 : 0);
      end
      if (we) begin
         m_gain[a]  = g;
         m_dwell[a] = d;
      end
      @(posedge clk); @(negedge clk);
      tick = 1'b0; cfg_we = 1'b0;
      check_all();
   endtask

   task automatic write_all_dwell(input int d);
      for (int k = 0; k < 4; k++) step(0, 16'sd0, 1, k, m_gain[k], d);
   endtask

   initial begin
      @(negedge clk);
      do_reset(0, 0);
      do_reset(0, 0);

      for (int i = 0; i < 5; i++) step(1, 16'sd1000, 0, 0, 0, 0);
      step(0, 16'sd5, 0, 0, 0, 0);

      step(0, 16'sd0, 1, 0, 64, 1000);
      step(1, -16'sd1001, 0, 0, 0, 0);
      chk("floor_neg", {16'h0, noise_out}, {16'h0, 16'hFE0B});
      step(0, 16'sd0, 1, 0, 255, 1000);
      step(1, 16'sd32767, 0, 0, 0, 0);
      chk("sat_pos", {16'h0, noise_out}, 32'h7FFF);
      step(1, -16'sd32768, 0, 0, 0, 0);
      chk("sat_neg", {16'h0, noise_out}, 32'h8000);

      // Restore unity on state 0 and shorten every dwell; current 1000-tick dwell runs out first.
      step(0, 16'sd0, 1, 0, 128, 3);
      write_all_dwell(3);
      for (int i = 0; i < 1030; i++) step(1, 16'($urandom), 0, 0, 0, 0);

      write_all_dwell(0);
      for (int i = 0; i < 25; i++) step(1, 16'($urandom), 0, 0, 0, 0);

      write_all_dwell(50);
      step(1, 16'sd10, 0, 0, 0, 0);
      step(1, 16'sd256, 1, m_state, 32, 50);
      chk("gain_old", {16'h0, noise_out}, 32'd256);
      step(1, 16'sd256, 0, 0, 0, 0);
      chk("gain_new", {16'h0, noise_out}, 32'd64);

      for (int i = 0; i < 7; i++) step(1, 16'($urandom), 0, 0, 0, 0);
      do_reset(1, 1);
      write_all_dwell(0);
      for (int i = 0; i < 20; i++) step(1, 16'sd1000, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
